pulse_stretcher: RTL and testbench

Converts single-cycle strobes (e.g. from the one-shot button conditioner) back into a level pulse. Each accepted trigger produces an output held high for a programmable number of clock cycles. An optional hold-off window follows each pulse.
Sits in the Counter area between push-button one-shots and slow consumers: LEDs, enables, visible indicators.

---
 rtl/pulse_stretcher.sv | 125 ++++++++++++
 tb/tb_pulse_stretcher.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle trigger strobes into level pulses of programmable length,
// with an optional hold-off window after each pulse. Define RETRIGGER_EN to let a trigger
// during an active pulse reload the remaining length instead of being reported as missed.
module pulse_stretcher #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trig,
    input  logic [WIDTH-1:0] len,
    input  logic [WIDTH-1:0] holdoff,
    output logic             out,
    output logic             busy,
    output logic             done,
    output logic             missed,
    output logic [CNT_W-1:0] pulse_cnt
);

`ifdef RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        HOLDOFF = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] holdoff_q, holdoff_d;
    logic             done_q, done_d;
    logic             missed_q, missed_d;
    logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
    logic             last_cycle;

    // cnt_q holds the cycles left in the current phase, including the present one.
    assign last_cycle = (cnt_q == ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            holdoff_q   <= '0;
            done_q      <= 1'b0;
            missed_q    <= 1'b0;
            pulse_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            holdoff_q   <= holdoff_d;
            done_q      <= done_d;
            missed_q    <= missed_d;
            pulse_cnt_q <= pulse_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        holdoff_d   = holdoff_q;
        done_d      = 1'b0;
        missed_d    = 1'b0;
        pulse_cnt_d = pulse_cnt_q;

        case (state_q)
            IDLE: begin
                if (trig && (len != '0)) begin
                    state_d     = ACTIVE;
                    cnt_d       = len;
                    holdoff_d   = holdoff;
                    pulse_cnt_d = pulse_cnt_q + 1'b1;
                end
            end

            ACTIVE: begin
                if (RETRIG && trig && (len != '0)) begin
                    cnt_d     = len;
                    holdoff_d = holdoff;
                end else begin
                    missed_d = trig && !RETRIG;
                    if (last_cycle) begin
                        done_d = 1'b1;
                        if (holdoff_q != '0) begin
                            state_d = HOLDOFF;
                            cnt_d   = holdoff_q;
                        end else begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
            end

            HOLDOFF: begin
                missed_d = trig;
                if (last_cycle) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign out       = (state_q == ACTIVE);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign missed    = missed_q;
    assign pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Randomized bench for pulse_stretcher: an interval-based reference model (pulse start edge,
// length, hold-off) predicts every output after every clock edge.
module tb_pulse_stretcher;
    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             trig;
    logic [WIDTH-1:0] len;
    logic [WIDTH-1:0] holdoff;
    logic             out;
    logic             busy;
    logic             done;
    logic             missed;
    logic [CNT_W-1:0] pulse_cnt;

    pulse_stretcher #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .trig     (trig),
        .len      (len),
        .holdoff  (holdoff),
        .out      (out),
        .busy     (busy),
        .done     (done),
        .missed   (missed),
        .pulse_cnt(pulse_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: the most recent pulse started at edge s, lasts L cycles, then H hold-off cycles.
    longint           e_now;
    bit               have_p;
    longint           s_edge, l_len, h_len;
    logic [CNT_W-1:0] cnt_m;
    logic             out_m, busy_m, done_m, missed_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s edge=%0d observed=%0h expected=%0h", tag, e_now, obs, exp);
    endtask

    task automatic model_reset();
        have_p   = 1'b0;
        cnt_m    = '0;
        out_m    = 1'b0;
        busy_m   = 1'b0;
        done_m   = 1'b0;
        missed_m = 1'b0;
    endtask

    task automatic model_edge(input logic t, input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] h);
        missed_m = 1'b0;
        if (!have_p || e_now > s_edge + l_len + h_len) begin
            if (t && l != 0) begin
                have_p = 1'b1;
                s_edge = e_now;
                l_len  = longint'(l);
                h_len  = longint'(h);
                cnt_m  = cnt_m + 1'b1;
            end
        end else if (t) begin
`ifdef RETRIGGER_EN
            if (e_now <= s_edge + l_len) begin
                if (l != 0) begin
                    s_edge = e_now;
                    l_len  = longint'(l);
                    h_len  = longint'(h);
                end
            end else begin
                missed_m = 1'b1;
            end
`else
            missed_m = 1'b1;
`endif
        end
        out_m  = have_p && (e_now < s_edge + l_len);
        busy_m = have_p && (e_now < s_edge + l_len + h_len);
        done_m = have_p && (e_now == s_edge + l_len);
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".out"},       32'(out),       32'(out_m));
        check({ctx, ".busy"},      32'(busy),      32'(busy_m));
        check({ctx, ".done"},      32'(done),      32'(done_m));
        check({ctx, ".missed"},    32'(missed),    32'(missed_m));
        check({ctx, ".pulse_cnt"}, 32'(pulse_cnt), 32'(cnt_m));
    endtask

    task automatic tick(input string ctx);
        @(posedge clk);
        e_now++;
        if (!rst_n) model_reset();
        else        model_edge(trig, len, holdoff);
        #1;
        check_all(ctx);
        if (trig || out || done || missed)
            $display("edge=%0d trig=%0b len=%0d hold=%0d out=%0b busy=%0b done=%0b missed=%0b cnt=%0d",
                     e_now, trig, len, holdoff, out, busy, done, missed, pulse_cnt);
    endtask

    task automatic drive(input logic t, input int l, input int h);
        trig    = t;
        len     = WIDTH'(l);
        holdoff = WIDTH'(h);
    endtask

    initial begin
        e_now = 0;
        s_edge = 0; l_len = 0; h_len = 0;
        model_reset();
        rst_n = 1'b0;
        drive(1'b1, 5, 0);
        #1;
        check_all("por");
        repeat (3) tick("reset_trig");
        rst_n = 1'b1;
        tick("release");
        drive(1'b0, 5, 0);
        repeat (10) tick("len5");

        // Hold-off window with repeated triggers: missed inside, accepted at first idle edge.
        drive(1'b1, 3, 4);
        tick("ho_start");
        drive(1'b0, 3, 4);
        repeat (4) tick("ho_run");
        drive(1'b1, 3, 4);
        repeat (30) tick("ho_trig");
        drive(1'b0, 3, 4);
        repeat (12) tick("ho_idle");

        drive(1'b1, 0, 2);
        repeat (4) tick("len0");

        // Back-to-back len=1 pulses, enough to wrap the pulse counter.
        drive(1'b1, 1, 0);
        repeat (530) tick("wrap");
        drive(1'b0, 1, 0);
        repeat (3) tick("wrap_idle");

        drive(1'b1, 255, 1);
        tick("maxlen_start");
        drive(1'b0, 0, 0);
        repeat (260) tick("maxlen");

        drive(1'b1, 8, 0);
        tick("retrig_start");
        drive(1'b0, 8, 0);
        repeat (3) tick("retrig_wait");
        drive(1'b1, 8, 0);
        tick("retrig_2nd");
        drive(1'b0, 8, 0);
        repeat (16) tick("retrig_tail");

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) == 0,
                  ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12)),
                  ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 5)));
            tick("rand");
        end
        drive(1'b0, 1, 0);
        repeat (20) tick("rand_drain");

        // Asynchronous reset in the middle of a pulse.
        drive(1'b1, 10, 2);
        tick("ar_start");
        drive(1'b0, 10, 2);
        repeat (3) tick("ar_run");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("ar_async");
        repeat (2) tick("ar_hold");
        #2;
        rst_n = 1'b1;
        repeat (15) tick("ar_after");
        drive(1'b1, 4, 0);
        tick("ar_new");
        drive(1'b0, 4, 0);
        repeat (8) tick("ar_new_run");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
